// File: rtl/clk_gen_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gen_ctrl
//
// Run-time programmable clock/PWM generator running from clk100. The derived
// clock clk_out has a period of `per` clk100 cycles and is high for the first
// `ton` cycles of each period. New {period, high time} pairs arrive through a
// valid/ready handshake. While running they are held in a one-deep pending
// slot and swapped in only at a period boundary, so clk_out never glitches.
//
// Optional feature (compile-time macro):
//   CLK_GEN_CTRL_SYNC_STOP_EN
//     defined   : stop lets the current period finish (STOPPING state), and
//                 clk_out ends low at the boundary with no runt pulse.
//     undefined : stop returns to IDLE at the next edge, and clk_out drops
//                 immediately.
//
// Parameters:
//   CNT_W      width of the period/high-time fields and of the counter
//   DEF_PERIOD active period after reset (clk100 cycles)
//   DEF_TON    active high time after reset (clk100 cycles)
//
// Ports:
//   clk100      in   sole clock, rising edge
//   rst         in   asynchronous, active-high reset
//   start       in   begin generating (level, sampled each edge)
//   stop        in   end generating (wins over start)
//   cfg_valid   in   configuration offered
//   cfg_ready   out  controller can accept a configuration (= !pend_v)
//   cfg_period  in   requested period
//   cfg_ton     in   requested high time
//   clk_out     out  generated clock, registered
//   busy        out  controller is not IDLE
//   period_done out  high during the last cycle of each period
//   cfg_err     out  one-cycle pulse after a rejected configuration
// -----------------------------------------------------------------------------
module clk_gen_ctrl #(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 4,
    parameter int DEF_TON    = 2
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_ton,
    output logic             clk_out,
    output logic             busy,
    output logic             period_done,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] DEF_PER_C = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_TON_C = CNT_W'(DEF_TON);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    // A configuration is usable only if the clock has both a high and a low
    // phase: period >= 2 and 1 <= ton <= period-1.
    function automatic logic cfg_legal(input logic [CNT_W-1:0] p,
                                       input logic [CNT_W-1:0] t);
        return (p >= CNT_W'(2)) && (t >= CNT_W'(1)) && (t < p);
    endfunction

    // Last cycle of the current period.
    function automatic logic is_boundary(input logic [CNT_W-1:0] c,
                                         input logic [CNT_W-1:0] p);
        return c == (p - CNT_W'(1));
    endfunction

    // Registered state
    state_t           state;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] ton;
    logic [CNT_W-1:0] pper;
    logic [CNT_W-1:0] pton;
    logic             pend_v;
    logic [CNT_W-1:0] cnt;
    logic             clk_out_q;
    logic             cfg_err_q;

    // Next-state values
    state_t           state_nxt;
    logic [CNT_W-1:0] per_nxt;
    logic [CNT_W-1:0] ton_nxt;
    logic [CNT_W-1:0] pper_nxt;
    logic [CNT_W-1:0] pton_nxt;
    logic             pend_v_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clk_out_nxt;
    logic             cfg_err_nxt;

    logic             xfer;
    logic             xfer_ok;
    logic             at_bound;

    assign cfg_ready   = !pend_v;
    assign xfer        = cfg_valid && cfg_ready;
    assign xfer_ok     = xfer && cfg_legal(cfg_period, cfg_ton);
    assign at_bound    = is_boundary(cnt, per);

    assign busy        = (state != ST_IDLE);
    assign period_done = (state != ST_IDLE) && at_bound;
    assign clk_out     = clk_out_q;
    assign cfg_err     = cfg_err_q;

    // ---- next-state / datapath decode --------------------------------------
    always_comb begin
        state_nxt   = state;
        per_nxt     = per;
        ton_nxt     = ton;
        pper_nxt    = pper;
        pton_nxt    = pton;
        pend_v_nxt  = pend_v;
        cnt_nxt     = cnt;
        clk_out_nxt = clk_out_q;
        // A rejected offer still completes the handshake; only the flag shows it.
        cfg_err_nxt = xfer && !xfer_ok;

        case (state)
            ST_IDLE: begin
                cnt_nxt     = '0;
                clk_out_nxt = 1'b0;
                // Nothing is running, so configurations go straight to the
                // active registers. A pending pair left over from a stop is
                // applied here; cfg_ready is low then, so no offer competes.
                if (pend_v) begin
                    per_nxt    = pper;
                    ton_nxt    = pton;
                    pend_v_nxt = 1'b0;
                end else if (xfer_ok) begin
                    per_nxt = cfg_period;
                    ton_nxt = cfg_ton;
                end
                if (start && !stop) begin
                    state_nxt   = ST_RUN;
                    cnt_nxt     = '0;
                    // ton >= 1 always, so the first cycle of a period is high.
                    clk_out_nxt = 1'b1;
                end
            end

            ST_RUN, ST_STOPPING: begin
                if (at_bound) begin
                    cnt_nxt = '0;
                    // pend_v and xfer are mutually exclusive (ready = !pend_v).
                    // An offer landing on the boundary is parked, not applied,
                    // so this period's successor still uses the old values.
                    if (pend_v) begin
                        per_nxt    = pper;
                        ton_nxt    = pton;
                        pend_v_nxt = 1'b0;
                    end else if (xfer_ok) begin
                        pper_nxt   = cfg_period;
                        pton_nxt   = cfg_ton;
                        pend_v_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (xfer_ok) begin
                        pper_nxt   = cfg_period;
                        pton_nxt   = cfg_ton;
                        pend_v_nxt = 1'b1;
                    end
                end

                // clk_out is registered, so it is computed from the count and
                // high time that will be in effect in the coming cycle.
                clk_out_nxt = (cnt_nxt < ton_nxt);

                if ((state == ST_RUN) && stop) begin
`ifdef CLK_GEN_CTRL_SYNC_STOP_EN
                    // Stopping on the last cycle means the period is already
                    // complete; go straight to IDLE instead of starting another.
                    if (at_bound) begin
                        state_nxt   = ST_IDLE;
                        cnt_nxt     = '0;
                        clk_out_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_STOPPING;
                    end
`else
                    // Immediate stop: the high phase may be cut short. Any
                    // pending configuration is kept and applied in IDLE.
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    clk_out_nxt = 1'b0;
`endif
                end else if ((state == ST_STOPPING) && at_bound) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    clk_out_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                cnt_nxt     = '0;
                clk_out_nxt = 1'b0;
            end
        endcase
    end

    // ---- state register ----------------------------------------------------
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            per       <= DEF_PER_C;
            ton       <= DEF_TON_C;
            pper      <= '0;
            pton      <= '0;
            pend_v    <= 1'b0;
            cnt       <= '0;
            clk_out_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            per       <= per_nxt;
            ton       <= ton_nxt;
            pper      <= pper_nxt;
            pton      <= pton_nxt;
            pend_v    <= pend_v_nxt;
            cnt       <= cnt_nxt;
            clk_out_q <= clk_out_nxt;
            cfg_err_q <= cfg_err_nxt;
        end
    end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_gen_ctrl
//
// Directed bench for clk_gen_ctrl. Inputs change and outputs are sampled on
// the falling edge of clk100, so every sample sees the settled result of the
// preceding rising edge.
// -----------------------------------------------------------------------------
module tb_clk_gen_ctrl;

    localparam int CNT_W = 16;

    logic             clk100;
    logic             rst;
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_ton;
    logic             clk_out;
    logic             busy;
    logic             period_done;
    logic             cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    clk_gen_ctrl #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (4),
        .DEF_TON    (2)
    ) dut (
        .clk100      (clk100),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_ton     (cfg_ton),
        .clk_out     (clk_out),
        .busy        (busy),
        .period_done (period_done),
        .cfg_err     (cfg_err)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    task automatic tick();
        @(negedge clk100);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (clk_out !== 1'b0)     begin n_fail++; $display("FAIL reset_clk_out got %b expected 0", clk_out); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_checks++; if (period_done !== 1'b0) begin n_fail++; $display("FAIL reset_period_done got %b expected 0", period_done); end
        n_checks++; if (cfg_err !== 1'b0)     begin n_fail++; $display("FAIL reset_cfg_err got %b expected 0", cfg_err); end
        n_checks++; if (cfg_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_cfg_ready got %b expected 1", cfg_ready); end
        rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_idle_busy got %b expected 0", busy); end
    endtask

    // Start with default 4/2 and watch three periods: 1,1,0,0 with
    // period_done on the fourth cycle. Leaves the DUT at cnt=0.
    task automatic test_defaults(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (clk_out !== ((i % 4) < 2))     begin n_fail++; $display("FAIL %s_clk cyc %0d got %b expected %b", tag, i, clk_out, ((i % 4) < 2)); end
            n_checks++; if (period_done !== ((i % 4) == 3)) begin n_fail++; $display("FAIL %s_pd cyc %0d got %b expected %b", tag, i, period_done, ((i % 4) == 3)); end
            n_checks++; if (busy !== 1'b1)                 begin n_fail++; $display("FAIL %s_busy cyc %0d got %b expected 1", tag, i, busy); end
            tick();
        end
    endtask

    // Entered at cnt=0 of a 4/2 period. Offer 10/4: the current period stays
    // 4/2, cfg_ready is low until the boundary, then 4 high / 6 low.
    task automatic test_reconfig();
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reconf_ready_pre got %b expected 1", cfg_ready); end
        cfg_valid  = 1'b1;
        cfg_period = 16'd10;
        cfg_ton    = 16'd4;
        tick();
        cfg_valid = 1'b0;
        for (int c = 1; c < 4; c++) begin
            n_checks++; if (clk_out !== (c < 2))       begin n_fail++; $display("FAIL reconf_old_clk cnt %0d got %b expected %b", c, clk_out, (c < 2)); end
            n_checks++; if (period_done !== (c == 3))  begin n_fail++; $display("FAIL reconf_old_pd cnt %0d got %b expected %b", c, period_done, (c == 3)); end
            n_checks++; if (cfg_ready !== 1'b0)        begin n_fail++; $display("FAIL reconf_ready_low cnt %0d got %b expected 0", c, cfg_ready); end
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (clk_out !== (c < 4))       begin n_fail++; $display("FAIL reconf_new_clk cnt %0d got %b expected %b", c, clk_out, (c < 4)); end
            n_checks++; if (period_done !== (c == 9))  begin n_fail++; $display("FAIL reconf_new_pd cnt %0d got %b expected %b", c, period_done, (c == 9)); end
            n_checks++; if (cfg_ready !== 1'b1)        begin n_fail++; $display("FAIL reconf_ready_high cnt %0d got %b expected 1", c, cfg_ready); end
            tick();
        end
    endtask

    // Entered at cnt=0 of a 10/4 period. Two illegal offers each give a
    // cfg_err pulse and leave the waveform at 10/4.
    task automatic test_illegal();
        cfg_valid  = 1'b1;
        cfg_period = 16'd5;
        cfg_ton    = 16'd5;
        tick();
        n_checks++; if (cfg_err !== 1'b1)   begin n_fail++; $display("FAIL illegal1_err got %b expected 1", cfg_err); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL illegal1_ready got %b expected 1", cfg_ready); end
        n_checks++; if (clk_out !== 1'b1)   begin n_fail++; $display("FAIL illegal1_clk got %b expected 1", clk_out); end
        cfg_period = 16'd1;
        cfg_ton    = 16'd0;
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (cfg_err !== 1'b1)   begin n_fail++; $display("FAIL illegal2_err got %b expected 1", cfg_err); end
        n_checks++; if (clk_out !== 1'b1)   begin n_fail++; $display("FAIL illegal2_clk got %b expected 1", clk_out); end
        tick();
        for (int c = 3; c < 10; c++) begin
            n_checks++; if (cfg_err !== 1'b0)         begin n_fail++; $display("FAIL illegal_err_clear cnt %0d got %b expected 0", c, cfg_err); end
            n_checks++; if (clk_out !== (c < 4))      begin n_fail++; $display("FAIL illegal_clk cnt %0d got %b expected %b", c, clk_out, (c < 4)); end
            n_checks++; if (period_done !== (c == 9)) begin n_fail++; $display("FAIL illegal_pd cnt %0d got %b expected %b", c, period_done, (c == 9)); end
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (clk_out !== (c < 4))      begin n_fail++; $display("FAIL illegal_next_clk cnt %0d got %b expected %b", c, clk_out, (c < 4)); end
            n_checks++; if (period_done !== (c == 9)) begin n_fail++; $display("FAIL illegal_next_pd cnt %0d got %b expected %b", c, period_done, (c == 9)); end
            tick();
        end
    endtask

    // Entered at cnt=0 of a 10/4 period. Switch to 8/4, then stop at cnt=1.
    task automatic test_stop();
        cfg_valid  = 1'b1;
        cfg_period = 16'd8;
        cfg_ton    = 16'd4;
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL stop_cnt0_clk got %b expected 1", clk_out); end
        tick();
        n_checks++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL stop_cnt1_clk got %b expected 1", clk_out); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
`ifdef CLK_GEN_CTRL_SYNC_STOP_EN
        for (int c = 2; c < 8; c++) begin
            n_checks++; if (clk_out !== (c < 4))      begin n_fail++; $display("FAIL stop_sync_clk cnt %0d got %b expected %b", c, clk_out, (c < 4)); end
            n_checks++; if (busy !== 1'b1)            begin n_fail++; $display("FAIL stop_sync_busy cnt %0d got %b expected 1", c, busy); end
            n_checks++; if (period_done !== (c == 7)) begin n_fail++; $display("FAIL stop_sync_pd cnt %0d got %b expected %b", c, period_done, (c == 7)); end
            tick();
        end
`endif
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (clk_out !== 1'b0)     begin n_fail++; $display("FAIL stop_idle_clk cyc %0d got %b expected 0", k, clk_out); end
            n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL stop_idle_busy cyc %0d got %b expected 0", k, busy); end
            n_checks++; if (period_done !== 1'b0) begin n_fail++; $display("FAIL stop_idle_pd cyc %0d got %b expected 0", k, period_done); end
            tick();
        end
    endtask

    task automatic test_start_stop_together();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL both_busy got %b expected 0", busy); end
        n_checks++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL both_clk got %b expected 0", clk_out); end
        start = 1'b0;
        stop  = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL both_after_busy got %b expected 0", busy); end
    endtask

    // In IDLE a legal offer loads straight into the active registers.
    // Leaves the DUT running 6/3 at cnt=0.
    task automatic test_idle_load();
        cfg_valid  = 1'b1;
        cfg_period = 16'd6;
        cfg_ton    = 16'd3;
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_load_ready got %b expected 1", cfg_ready); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL idle_load_busy got %b expected 0", busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (clk_out !== ((i % 6) < 3))      begin n_fail++; $display("FAIL idle_load_clk cyc %0d got %b expected %b", i, clk_out, ((i % 6) < 3)); end
            n_checks++; if (period_done !== ((i % 6) == 5)) begin n_fail++; $display("FAIL idle_load_pd cyc %0d got %b expected %b", i, period_done, ((i % 6) == 5)); end
            tick();
        end
    endtask

    // Reset asserted between clock edges while clk_out is high and a
    // configuration is pending: outputs clear without waiting for an edge.
    task automatic test_async_reset();
        cfg_valid  = 1'b1;
        cfg_period = 16'd10;
        cfg_ton    = 16'd4;
        tick();
        cfg_valid = 1'b0;
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL arst_pend_ready got %b expected 0", cfg_ready); end
        n_checks++; if (clk_out !== 1'b1)   begin n_fail++; $display("FAIL arst_pre_clk got %b expected 1", clk_out); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (clk_out !== 1'b0)   begin n_fail++; $display("FAIL arst_clk got %b expected 0", clk_out); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL arst_busy got %b expected 0", busy); end
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %b expected 1", cfg_ready); end
        tick();
        rst = 1'b0;
        tick();
        test_defaults("post_rst");
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_ton    = '0;

        test_reset();
        test_defaults("defaults");
        test_reconfig();
        test_illegal();
        test_stop();
        test_start_stop_together();
        test_idle_load();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gen_ctrl.md
# clk_gen_ctrl

Synthesizable, run-time programmable clock/PWM generator controller driven from the 100 MHz bench/system clock `clk100`. It produces a derived clock `clk_out` whose period and high time are counted in `clk100` cycles. It sequences start/stop and accepts new period/duty configurations through a valid/ready handshake, applying them only at period boundaries so `clk_out` never glitches. It replaces behavioural `#delay` clock tasks wherever a derived clock must be reconfigured while the design runs.

## Interface
- `CNT_W`, 16, width of period/high-time fields and internal counter
- `DEF_PERIOD`, 4, active period after reset (clk100 cycles)
- `DEF_TON`, 2, active high time after reset (clk100 cycles)

- `clk100` in 1: sole clock, all logic on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: begin generating (level sampled each edge)
- `stop` in 1: end generating
- `cfg_valid` in 1: configuration offered
- `cfg_ready` out 1: controller can accept a configuration
- `cfg_period` in CNT_W: requested period
- `cfg_ton` in CNT_W: requested high time
- `clk_out` out 1: generated clock, registered
- `busy` out 1: state is not IDLE
- `period_done` out 1: one-cycle pulse on last cycle of each period
- `cfg_err` out 1: one-cycle pulse, offered configuration rejected

## Operation
- Registers: active `{per,ton}` (reset `DEF_PERIOD`/`DEF_TON`), pending `{pper,pton}` + `pend_v` (reset 0), counter `cnt` (reset 0), state (reset IDLE).
- Reset values of all outputs: `clk_out`=0, `busy`=0, `period_done`=0, `cfg_err`=0, `cfg_ready`=1.
- Config legality: `cfg_period` >= 2 and 1 <= `cfg_ton` <= `cfg_period`-1. Illegal -> handshake still completes, nothing stored, `cfg_err`=1 the next cycle.
- `cfg_ready` = !`pend_v`. Transfer when `cfg_valid && cfg_ready`.
- IDLE: a legal transfer loads active registers directly at that edge. `start`=1 and `stop`=0 -> RUN, `cnt`<=0, `clk_out`<=1.
- RUN: `cnt` increments each cycle. `clk_out`<=1 when next `cnt` < `ton`, else 0. Boundary is `cnt`==`per`-1. At the boundary: `period_done`=1, `cnt`<=0; if `pend_v`, active<=pending and `pend_v`<=0, so the new values take effect from the first cycle of the next period. A legal transfer in RUN loads pending.
- A transfer that coincides with a boundary goes to pending and is applied at the following boundary.
- `start` while RUN is ignored. `start` and `stop` in the same cycle: `stop` wins.
- STOPPING (macro only): behaves as RUN. At the boundary -> IDLE, `clk_out`<=0. `start` is ignored while in STOPPING.
- Pending configuration survives a stop and is applied at the next edge in IDLE.
- `rst` asserted mid-operation immediately forces all registers to reset values, including any pending configuration.

## Timing
- Start latency: `start` sampled at edge k -> `clk_out` high from edge k for `ton` cycles, then low for `per`-`ton` cycles, repeating.
- `period_done` is high during the cycle where `cnt`==`per`-1, which is the last low cycle.
- `cfg_err` asserts one cycle after the rejected transfer.
- `cfg_ready` deasserts the cycle after a legal transfer in RUN, and reasserts the cycle after the boundary that consumes it.
- Counter width: `cnt` is CNT_W bits. Legal configurations guarantee no wrap.

## Configuration
- `CLK_GEN_CTRL_SYNC_STOP_EN` defined: `stop` in RUN -> STOPPING. The current period completes, and `clk_out` ends low at the boundary with no runt pulse. `busy` stays 1 until IDLE.
- Not defined: `stop` in RUN -> IDLE at the next edge, `clk_out`<=0 immediately. A high phase may be truncated.

## Test plan
- Reset defaults: release `rst`, pulse `start` -> `clk_out` repeats 1,1,0,0; `period_done` on every 4th cycle.
- Reconfig mid-run: in RUN send period=10, ton=4 -> `cfg_ready` low until the boundary. The next period is exactly 4 high / 6 low, and no earlier period is altered.
- Illegal config: send period=5, ton=5, then period=1, ton=0 -> `cfg_err` pulses for each; the waveform is unchanged.
- Stop, macro defined: stop at cnt=1 of period=8, ton=4 -> the period finishes, `clk_out` reaches IDLE low after cnt=7, then `busy`=0. Macro undefined: `clk_out`=0 and `busy`=0 one edge after stop.
- Start and stop asserted together in IDLE -> stays IDLE, `clk_out`=0.
- Async `rst` during a high phase -> `clk_out`, `busy`, and `pend_v` go to 0 immediately without waiting for an edge; after release, behaviour resumes with the DEF values.
